default_slave_write: RTL and testbench

Write-path default slave for the AXI interconnect. It terminates write transactions decoded to no mapped slave. It accepts one AW request, then consumes all W beats of that burst. It then returns a single DECERR write response on the DS port of the B-channel arbiter (BVALID_DS/BID_DS/BREADY_DS). Only one transaction is outstanding at a time; no data is stored.

---
 rtl/default_slave_write.sv | 75 +++++++
 tb/tb_default_slave_write.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/default_slave_write.sv
// default_slave_write: terminates unmapped AXI writes by consuming one burst and returning DECERR
module default_slave_write #(
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   AWID_DS,
    input  logic [LEN_W-1:0]  AWLEN_DS,
    input  logic              AWVALID_DS,
    output logic              AWREADY_DS,
    input  logic [DATA_W-1:0] WDATA_DS,
    input  logic              WLAST_DS,
    input  logic              WVALID_DS,
    output logic              WREADY_DS,
    output logic [ID_W-1:0]   BID_DS,
    output logic [1:0]        BRESP_DS,
    output logic              BVALID_DS,
    input  logic              BREADY_DS,
    output logic              LEN_ERR
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t             r_state;
    logic [ID_W-1:0]    r_id;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_len_err;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_last_idx;
    logic               w_unused;
    assign w_unused   = ^WDATA_DS;
    // Handshake outputs are masked by reset so they read 0 in the very cycle reset is raised.
    assign AWREADY_DS = !ARESET && r_state == IDLE;
    assign WREADY_DS  = !ARESET && r_state == DATA;
    assign BVALID_DS  = !ARESET && r_state == RESP;
    assign BRESP_DS   = BVALID_DS ? 2'b11 : 2'b00;
    assign BID_DS     = ARESET ? '0 : r_id;
    assign LEN_ERR    = !ARESET && r_len_err;
    assign w_aw_hs    = AWVALID_DS && AWREADY_DS;
    assign w_w_hs     = WVALID_DS && WREADY_DS;
    assign w_b_hs     = BVALID_DS && BREADY_DS;
    assign w_last_idx = r_cnt == r_len;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            unique case (r_state)
                IDLE: if (w_aw_hs) begin
                    r_id    <= AWID_DS;
                    r_len   <= AWLEN_DS;
                    r_cnt   <= '0;
                    r_state <= DATA;
                end
                DATA: if (w_w_hs) begin
                    r_cnt <= r_cnt + 1'b1;
                    // Whichever of WLAST or the AWLEN count comes first ends the burst.
                    if (WLAST_DS || w_last_idx) begin
                        r_state   <= RESP;
                        r_len_err <= WLAST_DS != w_last_idx;
                    end
                end
                RESP: if (w_b_hs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_default_slave_write.sv
// tb_default_slave_write: randomized transaction-level check of the write default slave
module tb_default_slave_write;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID_DS;
    logic [3:0]  AWLEN_DS;
    logic        AWVALID_DS;
    logic        AWREADY_DS;
    logic [31:0] WDATA_DS;
    logic        WLAST_DS;
    logic        WVALID_DS;
    logic        WREADY_DS;
    logic [7:0]  BID_DS;
    logic [1:0]  BRESP_DS;
    logic        BVALID_DS;
    logic        BREADY_DS;
    logic        LEN_ERR;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int a1, a2, a;

    default_slave_write #(.ID_W(8), .LEN_W(4), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID_DS(AWID_DS), .AWLEN_DS(AWLEN_DS), .AWVALID_DS(AWVALID_DS), .AWREADY_DS(AWREADY_DS),
        .WDATA_DS(WDATA_DS), .WLAST_DS(WLAST_DS), .WVALID_DS(WVALID_DS), .WREADY_DS(WREADY_DS),
        .BID_DS(BID_DS), .BRESP_DS(BRESP_DS), .BVALID_DS(BVALID_DS), .BREADY_DS(BREADY_DS),
        .LEN_ERR(LEN_ERR)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_awready"}, AWREADY_DS, 0);
        chk({tag, "_wready"}, WREADY_DS, 0);
        chk({tag, "_bvalid"}, BVALID_DS, 0);
        chk({tag, "_bid"}, BID_DS, 0);
        chk({tag, "_bresp"}, BRESP_DS, 0);
        chk({tag, "_len_err"}, LEN_ERR, 0);
    endtask

    // Entered just after a negedge with the slave idle. wl is the beat carrying WLAST (0 = never).
    task automatic txn(input logic [7:0] id, input int len, input int wl, input bit gaps,
                       input int hold, input bit stray, output int aw_at);
        int  n_exp = (wl >= 1 && wl <= len + 1) ? wl : len + 1;
        bit  e_err = (wl != len + 1);
        int  beats = 0;
        int  tries = 0;
        bit  v;
        chk("aw_ready_idle", AWREADY_DS, 1);
        AWVALID_DS = 1; AWID_DS = id; AWLEN_DS = 4'(len);
        @(negedge ACLK);
        aw_at = cyc;
        AWVALID_DS = 0;
        while (beats < n_exp) begin
            chk("w_ready", WREADY_DS, 1);
            chk("b_valid_data", BVALID_DS, 0);
            chk("len_err_data", LEN_ERR, 0);
            chk("aw_ready_data", AWREADY_DS, 0);
            v = !gaps || tries > 20 || $urandom_range(0, 2) != 0;
            tries++;
            WVALID_DS = v; WLAST_DS = v && (beats + 1 == wl); WDATA_DS = $urandom;
            @(negedge ACLK);
            if (v) beats++;
        end
        WVALID_DS = 0; WLAST_DS = 0;
        chk("w_ready_resp", WREADY_DS, 0);
        chk("b_valid", BVALID_DS, 1);
        chk("b_id", BID_DS, id);
        chk("b_resp", BRESP_DS, 2'b11);
        chk("len_err", LEN_ERR, e_err);
        for (int i = 0; i < hold; i++) begin
            AWVALID_DS = stray; AWID_DS = ~id; AWLEN_DS = 0; WVALID_DS = stray; WLAST_DS = stray;
            @(negedge ACLK);
            chk("b_valid_hold", BVALID_DS, 1);
            chk("b_id_hold", BID_DS, id);
            chk("b_resp_hold", BRESP_DS, 2'b11);
            chk("len_err_hold", LEN_ERR, 0);
            chk("aw_ready_hold", AWREADY_DS, 0);
            chk("w_ready_hold", WREADY_DS, 0);
        end
        AWVALID_DS = 0; WVALID_DS = 0; WLAST_DS = 0; BREADY_DS = 1;
        @(negedge ACLK);
        BREADY_DS = 0;
        chk("b_valid_done", BVALID_DS, 0);
        chk("b_resp_done", BRESP_DS, 0);
        chk("b_id_done", BID_DS, id);
        chk("aw_ready_done", AWREADY_DS, 1);
        chk("len_err_done", LEN_ERR, 0);
    endtask

    initial begin
        ARESET = 1; AWID_DS = 0; AWLEN_DS = 0; AWVALID_DS = 0;
        WDATA_DS = 0; WLAST_DS = 0; WVALID_DS = 0; BREADY_DS = 0;
        repeat (3) @(negedge ACLK);
        chk_zero("rst");
        ARESET = 0;
        @(negedge ACLK);
        txn(8'h85, 0, 1, 0, 0, 0, a);
        txn(8'h3C, 3, 4, 1, 1, 0, a);
        txn(8'h42, 3, 2, 1, 0, 0, a);
        txn(8'h43, 3, 0, 1, 0, 0, a);
        txn(8'h5A, 1, 2, 0, 10, 1, a);
        txn(8'h81, 0, 1, 0, 0, 0, a1);
        txn(8'h9F, 0, 1, 0, 0, 0, a2);
        chk("aw_spacing", a2 - a1, 3);
        txn(8'h07, 0, 0, 0, 0, 0, a);
        txn(8'hC7, 15, 16, 1, 2, 0, a);
        txn(8'hC8, 15, 0, 1, 0, 0, a);
        // Reset after two of four beats: aborted transaction yields no response.
        AWVALID_DS = 1; AWID_DS = 8'hE1; AWLEN_DS = 3;
        @(negedge ACLK);
        AWVALID_DS = 0; WVALID_DS = 1; WLAST_DS = 0;
        repeat (2) @(negedge ACLK);
        WVALID_DS = 0; ARESET = 1;
        #1 chk_zero("rst_mid");
        @(negedge ACLK);
        chk_zero("rst_mid_held");
        ARESET = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("rst_no_bvalid", BVALID_DS, 0);
            chk("rst_aw_ready", AWREADY_DS, 1);
        end
        txn(8'hE2, 2, 3, 1, 1, 0, a);
        for (int k = 0; k < 25; k++) begin
            int len = $urandom_range(0, 15);
            int m = $urandom_range(0, 3);
            int wl = m == 0 ? 0 : m == 1 ? len + 1 : $urandom_range(1, 17);
            txn(8'($urandom), len, wl, 1, $urandom_range(0, 4), 1'($urandom_range(0, 1)), a);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
